// File: rtl/cout_div_stage_if.sv
// Handshake/bus bundle for cout_div_stage.
// Parameters:
//   WIDTH - width of the divisor value div_n
//   EVT_W - width of the saturating tick counter evt_cnt
// Signals:
//   en, cout_in, div_n, load, clear_evt  : driven by the master (controller / upstream)
//   tick_out, sq_out, evt_cnt, ovf_err   : driven by the slave (the divider stage)
interface cout_div_stage_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned EVT_W = 16
) ();
    logic             en;
    logic             cout_in;
    logic [WIDTH-1:0] div_n;
    logic             load;
    logic             clear_evt;
    logic             tick_out;
    logic             sq_out;
    logic [EVT_W-1:0] evt_cnt;
    logic             ovf_err;

    modport master (
        output en, cout_in, div_n, load, clear_evt,
        input  tick_out, sq_out, evt_cnt, ovf_err
    );

    modport slave (
        input  en, cout_in, div_n, load, clear_evt,
        output tick_out, sq_out, evt_cnt, ovf_err
    );
endinterface

// File: rtl/cout_div_stage.sv
// cout_div_stage: divides the upstream counter's carry-out pulse train by a
// runtime-programmable N, producing a one-cycle tick, a 50%-duty square wave
// and a saturating tick count with a sticky overflow flag.
//
// Ports:
//   clk  - system clock, all state on rising edge
//   rst  - asynchronous active-low reset
//   bus  - cout_div_stage_if.slave:
//          en        event-count enable (low freezes counting)
//          cout_in   upstream carry-out, may stay high for several cycles
//          div_n     divisor, latched when load=1 (0 behaves as 1)
//          load      latch div_n and restart the division
//          clear_evt clear evt_cnt and ovf_err
//          tick_out  one-cycle pulse every N events
//          sq_out    toggles on every tick
//          evt_cnt   saturating tick count
//          ovf_err   sticky: tick seen while evt_cnt was all-ones
//
// Optional feature (macro COUT_SYNC_EN): adds a two-flop synchronizer on
// cout_in ahead of the edge detector for an asynchronous upstream clock;
// event-to-tick latency grows by two cycles.
module cout_div_stage #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DIV_DEFAULT = 2,
    parameter int unsigned EVT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    cout_div_stage_if.slave    bus
);

    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    logic             w_cout;
    logic             w_rise;
    logic [WIDTH-1:0] w_div_eff;
    logic             w_last;
    logic             w_step;
    logic             w_tick;

    logic             r_cout;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_q;
    logic             r_tick;
    logic             r_sq;
    logic [EVT_W-1:0] r_evt;
    logic             r_ovf;

`ifdef COUT_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchronizer for a cout_in from a foreign clock domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.cout_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_cout = r_sync2;
`else
    assign w_cout = bus.cout_in;
`endif

    // Rising-edge event; a stretched carry-out counts once
    assign w_rise    = w_cout & ~r_cout;

    // A zero divisor is treated as divide-by-one rather than a stall
    assign w_div_eff = (r_div_q == '0) ? WIDTH'(1) : r_div_q;
    assign w_last    = (r_cnt == (w_div_eff - WIDTH'(1)));

    // Load takes priority: a coincident event is dropped
    assign w_step    = bus.en & w_rise & ~bus.load;
    assign w_tick    = w_step & w_last;

    // Edge tracking keeps running while disabled so re-enable on a high
    // cout_in does not fabricate an event
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cout <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_cout <= w_cout;
            r_tick <= w_tick;
        end
    end

    // Divisor register, event counter and square wave
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_q <= WIDTH'(DIV_DEFAULT);
            r_cnt   <= '0;
            r_sq    <= 1'b0;
        end else if (bus.load) begin
            r_div_q <= bus.div_n;
            r_cnt   <= '0;
            r_sq    <= 1'b0;
        end else if (w_step) begin
            if (w_last) begin
                r_cnt <= '0;
                r_sq  <= ~r_sq;
            end else begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
        end
    end

    // Saturating tick counter; clear beats a coincident tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_evt <= '0;
            r_ovf <= 1'b0;
        end else if (bus.clear_evt) begin
            r_evt <= '0;
            r_ovf <= 1'b0;
        end else if (w_tick) begin
            if (r_evt == EVT_MAX) begin
                r_ovf <= 1'b1;
            end else begin
                r_evt <= r_evt + EVT_W'(1);
            end
        end
    end

    assign bus.tick_out = r_tick;
    assign bus.sq_out   = r_sq;
    assign bus.evt_cnt  = r_evt;
    assign bus.ovf_err  = r_ovf;

endmodule
